btn_cmd_arbiter: RTL and testbench
==================================

# btn_cmd_arbiter

Collects the single-clock enable pulses from the per-button debouncers (N_BTN instances, one per board pushbutton) and serialises them into one command stream for the minesweeper game core. Each button has a one-deep pending slot. A round-robin arbiter grants one pending button at a time, and a valid/ready handshake delivers the granted button index to the core. The block sits between the debouncer bank and the game-state FSM, so the core never sees two button events in the same cycle.

## Interface
- N_BTN, 5, number of buttons (2..8)
- IDX_W, 3, width of CMD_IDX; must satisfy 2^IDX_W >= N_BTN
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- DPB  in  N_BTN  debounced button levels, bit i = button i
- SCEN  in  N_BTN  single-clock enable pulse per button (first press)
- MCEN  in  N_BTN  multi-clock enable pulse per button (auto-repeat)
- CMD_READY  in  1  game core accepts the command this cycle
- CMD_VALID  out  1  command available
- CMD_IDX  out  IDX_W  granted button index
- CMD_REPEAT  out  1  1 = command originated from MCEN, 0 = from SCEN
- PEND  out  N_BTN  pending-slot occupancy (registered)
- DROP  out  1  one-cycle pulse: an event hit an already-full slot
- BUSY  out  1  FSM not in IDLE

## Operation
- Per button i: pending bit P[i] and repeat flag R[i].
- SCEN[i] sets P[i]=1 and R[i]=0. MCEN[i] sets P[i]=1 and R[i]=1, only when the macro is enabled.
- If SCEN[i] and MCEN[i] are both high in one cycle, SCEN wins (R[i]=0).
- Event arriving while P[i]=1 and slot not being cleared that cycle: event discarded, original P/R kept, DROP=1 next cycle.
- Multiple drops in one cycle produce a single DROP pulse.
- Grant clears P[i]. A new event on i in the same cycle as its grant re-sets P[i]; this is not a drop.
- Stale-repeat cancel: while DPB[i]=0, a pending slot with R[i]=1 is cleared. SCEN-originated slots are never cancelled.
- Round-robin pointer PTR (0..N_BTN-1):
  - Search for a pending button starts at PTR and wraps modulo N_BTN.
  - After a grant to button g, PTR = g+1 mod N_BTN.
- FSM states:
  - IDLE: if any P set, latch CMD_IDX=g and CMD_REPEAT=R[g], clear P[g], update PTR, go to ISSUE. Otherwise stay.
  - ISSUE: CMD_VALID=1. CMD_IDX and CMD_REPEAT are held stable. On CMD_READY=1, go to GAP.
  - GAP: CMD_VALID=0 for exactly one cycle, then go to IDLE.
- Handshake:
  - Transfer occurs on a rising edge with CMD_VALID=1 and CMD_READY=1.
  - VALID never drops without a transfer.
  - READY may be asserted before VALID; it has no effect outside ISSUE.
- Unused IDX_W bits above log2(N_BTN) are driven 0.

## Timing
- All outputs are registered.
- Reset values: CMD_VALID=0, CMD_IDX=0, CMD_REPEAT=0, PEND=0, DROP=0, BUSY=0, PTR=0, state IDLE.
- Latency:
  - Pulse sampled at edge k → PEND[i]=1 after edge k.
  - Grant at edge k+1 → CMD_VALID=1 after edge k+1.
- Minimum spacing is 3 cycles per command (IDLE, ISSUE, GAP) when READY is tied high.
- PEND reflects state after the edge. DROP is high for exactly one cycle after the offending edge.
- RESET asserted mid-ISSUE immediately forces CMD_VALID=0 and clears all slots. Commands are not replayed after reset.
- Pulses arriving during RESET are ignored.

## Configuration
- BTN_ARB_REPEAT_EN defined:
  - MCEN pulses create repeat commands (CMD_REPEAT=1).
  - Stale-repeat cancel is active.
- BTN_ARB_REPEAT_EN undefined:
  - MCEN is ignored entirely.
  - R flags and CMD_REPEAT are tied 0.
  - Cancel logic is removed.
  - DPB is unused.

## Test plan
- Reset, READY=1, SCEN[2] pulse at edge 10 → PEND=00100 after 10; CMD_VALID=1, CMD_IDX=2, CMD_REPEAT=0 after edge 11; VALID=0 after edge 12; BUSY=0 after 13.
- READY=0. Grant button 1, then pulse SCEN[0], SCEN[1], SCEN[2] together, then release READY=1 → command order 1, 2, 0, 1 (PTR round-robin from 2).
- READY=0 with button 3 granted. Pulse SCEN[4], then SCEN[4] again 2 cycles later → DROP high one cycle; PEND[4] stays 1; only one command for 4 follows.
- Macro on, DPB[1]=1: MCEN[1] pulse → CMD_REPEAT=1. Second MCEN[1] while READY=0, then DPB[1]→0 → PEND[1] clears; no extra command. Macro off: same stimulus → no MCEN-derived commands.
- RESET pulse while CMD_VALID=1 with PEND=10010 → all outputs 0 after reset. Next SCEN[4] is granted first from PTR=0 search (yields 4).
- SCEN[1] on the same edge its slot is granted (PEND[1] previously 1) → no DROP; a second command for 1 follows after GAP.

Source files
------------

// File: rtl/btn_cmd_arbiter_if.sv
// Command handshake between btn_cmd_arbiter (master) and the game core (slave).
// Carries the granted button index and its repeat flag under valid/ready.
interface btn_cmd_arbiter_if #(
  parameter int unsigned IDX_W = 3
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [IDX_W-1:0] CMD_IDX;
  logic             CMD_REPEAT;

  modport master (
    output CMD_VALID,
    output CMD_IDX,
    output CMD_REPEAT,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_IDX,
    input  CMD_REPEAT,
    output CMD_READY
  );
endinterface

// File: rtl/btn_cmd_arbiter.sv
// Serialises per-button debouncer pulses into one round-robin command stream.
// Define BTN_ARB_REPEAT_EN to accept MCEN auto-repeat events and cancel stale repeats.
module btn_cmd_arbiter #(
  parameter int unsigned N_BTN = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_BTN-1:0]  DPB,
  input  logic [N_BTN-1:0]  SCEN,
  input  logic [N_BTN-1:0]  MCEN,
  btn_cmd_arbiter_if.master cmd,
  output logic [N_BTN-1:0]  PEND,
  output logic              DROP,
  output logic              BUSY
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e           state_q, state_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cmd_idx_q, cmd_idx_d;
  logic             cmd_rep_q, cmd_rep_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic [N_BTN-1:0] ev, ev_rep, cancel, clr, take;
  logic             found, grant;
  logic [IDX_W-1:0] gnt_idx, cand;

`ifdef BTN_ARB_REPEAT_EN
  assign ev     = SCEN | MCEN;
  assign ev_rep = MCEN & ~SCEN;
  // Repeat commands are stale once the button has been released.
  assign cancel = pend_q & rep_q & ~DPB;
`else
  logic unused_in;
  assign ev        = SCEN;
  assign ev_rep    = '0;
  assign cancel    = '0;
  assign unused_in = ^{DPB, MCEN};
`endif

  // First pending slot at or after ptr_q, wrapping modulo N_BTN.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_BTN);
      if (!found && pend_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cmd_idx_d = cmd_idx_q;
    cmd_rep_d = cmd_rep_q;
    grant     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant     = 1'b1;
          cmd_idx_d = gnt_idx;
          cmd_rep_d = rep_q[gnt_idx];
          ptr_d     = (32'(gnt_idx) == N_BTN - 1) ? '0 : gnt_idx + IDX_W'(1);
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (cmd.CMD_READY) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    valid_d = (state_d == StIssue);
    busy_d  = (state_d != StIdle);
  end

  // A slot being granted or cancelled this cycle may accept a new event without a drop.
  always_comb begin
    clr    = cancel;
    if (grant) clr = clr | (N_BTN'(1) << gnt_idx);
    take   = ev & (~pend_q | clr);
    pend_d = take | (pend_q & ~clr);
    rep_d  = (take & ev_rep) | (rep_q & ~clr & ~take);
    drop_d = |(ev & pend_q & ~clr);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      rep_q     <= '0;
      ptr_q     <= '0;
      cmd_idx_q <= '0;
      cmd_rep_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      rep_q     <= rep_d;
      ptr_q     <= ptr_d;
      cmd_idx_q <= cmd_idx_d;
      cmd_rep_q <= cmd_rep_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign cmd.CMD_VALID  = valid_q;
  assign cmd.CMD_IDX    = cmd_idx_q;
  assign cmd.CMD_REPEAT = cmd_rep_q;
  assign PEND           = pend_q;
  assign DROP           = drop_q;
  assign BUSY           = busy_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter: per-cycle check against a slot/arbiter model
// plus literal expectations on handshake timing and command order.
module tb_btn_cmd_arbiter;
  localparam int unsigned N  = 5;
  localparam int unsigned IW = 3;
`ifdef BTN_ARB_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  logic         CLK   = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] DPB   = '0;
  logic [N-1:0] SCEN  = '0;
  logic [N-1:0] MCEN  = '0;
  logic [N-1:0] PEND;
  logic         DROP, BUSY;

  btn_cmd_arbiter_if #(.IDX_W(IW)) cmd_if ();

  btn_cmd_arbiter #(.N_BTN(N), .IDX_W(IW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .DPB  (DPB),
    .SCEN (SCEN),
    .MCEN (MCEN),
    .cmd  (cmd_if),
    .PEND (PEND),
    .DROP (DROP),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: command slot is either offered (m_valid), in its one-cycle gap, or free.
  logic [N-1:0] m_pend = '0, m_rep = '0;
  int           m_ptr = 0, m_idx = 0;
  logic         m_valid = 1'b0, m_gap = 1'b0, m_drop = 1'b0, m_crep = 1'b0;

  always @(posedge CLK or posedge RESET) begin : model
    if (RESET) begin
      m_pend <= '0; m_rep <= '0; m_ptr <= 0; m_idx <= 0;
      m_valid <= 1'b0; m_gap <= 1'b0; m_drop <= 1'b0; m_crep <= 1'b0;
    end else begin : step
      logic [N-1:0] ev, evr, cl, np, nr;
      int g;
      bit d;
      g = -1;
      if (!m_valid && !m_gap)
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      ev  = SCEN | (RepOn ? MCEN : '0);
      evr = RepOn ? (MCEN & ~SCEN) : '0;
      cl  = RepOn ? (m_pend & m_rep & ~DPB) : '0;
      if (g >= 0) cl[g] = 1'b1;
      np = m_pend;
      nr = m_rep;
      d  = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (ev[i]) begin
          if (m_pend[i] && !cl[i]) d = 1'b1;
          else begin np[i] = 1'b1; nr[i] = evr[i]; end
        end else if (cl[i]) begin
          np[i] = 1'b0; nr[i] = 1'b0;
        end
      end
      m_pend <= np;
      m_rep  <= nr;
      m_drop <= d;
      if (g >= 0) begin
        m_valid <= 1'b1; m_idx <= g; m_crep <= m_rep[g]; m_ptr <= (g + 1) % N;
      end else if (m_valid && cmd_if.CMD_READY) begin
        m_valid <= 1'b0; m_gap <= 1'b1;
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("cycle{valid,idx,rep,pend,drop,busy}",
        32'({cmd_if.CMD_VALID, cmd_if.CMD_IDX, cmd_if.CMD_REPEAT, PEND, DROP, BUSY}),
        32'({m_valid, 3'(m_idx), m_crep, m_pend, m_drop, m_valid | m_gap}));
    if (cmd_if.CMD_VALID && cmd_if.CMD_READY) log_q.push_back(int'(cmd_if.CMD_IDX));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] s, input logic [N-1:0] m);
    SCEN = s;
    MCEN = m;
    tick();
    SCEN = '0;
    MCEN = '0;
  endtask

  task automatic wait_idle(input string name, input int n, input int budget);
    int c;
    c = 0;
    while ((log_q.size() < n || BUSY || PEND != '0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d commands expected %0d", name, log_q.size(), n);
    end
  endtask

  task automatic check_log(input string name, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int exp_q[4];
    exp_q = '{e0, e1, e2, e3};
    chk({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({name, "_order"}, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cmds", log_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.CMD_READY = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(cmd_if.CMD_VALID), 32'd0);
    chk("rst_pend", 32'(PEND), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    repeat (2) tick();

    // Single press: pending, then one-cycle grant latency, then GAP.
    pulse(5'b00100, '0);
    chk("t1_pend", 32'(PEND), 32'b00100);
    chk("t1_valid0", 32'(cmd_if.CMD_VALID), 32'd0);
    tick();
    chk("t1_valid1", 32'(cmd_if.CMD_VALID), 32'd1);
    chk("t1_idx", 32'(cmd_if.CMD_IDX), 32'd2);
    chk("t1_rep", 32'(cmd_if.CMD_REPEAT), 32'd0);
    tick();
    chk("t1_gap_valid", 32'(cmd_if.CMD_VALID), 32'd0);
    chk("t1_gap_busy", 32'(BUSY), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(BUSY), 32'd0);
    check_log("t1", 1, 2, 0, 0, 0);

    // Round robin: 1 held, then 0/1/2 arrive together; pointer sits at 2.
    cmd_if.CMD_READY = 1'b0;
    pulse(5'b00010, '0);
    tick();
    chk("t2_idx", 32'(cmd_if.CMD_IDX), 32'd1);
    pulse(5'b00111, '0);
    chk("t2_pend", 32'(PEND), 32'b00111);
    cmd_if.CMD_READY = 1'b1;
    wait_idle("t2_wait", 4, 40);
    check_log("t2", 4, 1, 2, 0, 1);

    // Drop on a full slot while 3 is stalled.
    cmd_if.CMD_READY = 1'b0;
    pulse(5'b01000, '0);
    tick();
    chk("t3_idx", 32'(cmd_if.CMD_IDX), 32'd3);
    pulse(5'b10000, '0);
    tick();
    pulse(5'b10000, '0);
    chk("t3_drop1", 32'(DROP), 32'd1);
    chk("t3_pend", 32'(PEND), 32'b10000);
    tick();
    chk("t3_drop0", 32'(DROP), 32'd0);
    cmd_if.CMD_READY = 1'b1;
    wait_idle("t3_wait", 2, 40);
    check_log("t3", 2, 3, 4, 0, 0);

    // Auto-repeat, then stale-repeat cancel when the button is released.
    cmd_if.CMD_READY = 1'b0;
    DPB = 5'b00010;
    pulse('0, 5'b00010);
    chk("t4_pend_a", 32'(PEND), RepOn ? 32'b00010 : 32'd0);
    tick();
    chk("t4_valid", 32'(cmd_if.CMD_VALID), 32'(RepOn));
    chk("t4_rep", 32'(cmd_if.CMD_REPEAT), 32'(RepOn));
    pulse('0, 5'b00010);
    chk("t4_pend_b", 32'(PEND), RepOn ? 32'b00010 : 32'd0);
    DPB = '0;
    tick();
    chk("t4_cancel", 32'(PEND), 32'd0);
    cmd_if.CMD_READY = 1'b1;
    wait_idle("t4_wait", RepOn ? 1 : 0, 40);
    check_log("t4", RepOn ? 1 : 0, 1, 0, 0, 0);

    // Asynchronous reset mid-ISSUE; no replay afterwards.
    cmd_if.CMD_READY = 1'b0;
    pulse(5'b00001, '0);
    tick();
    pulse(5'b10010, '0);
    chk("t5_pend", 32'(PEND), 32'b10010);
    chk("t5_valid", 32'(cmd_if.CMD_VALID), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t5_rst_out", 32'({cmd_if.CMD_VALID, cmd_if.CMD_IDX, cmd_if.CMD_REPEAT, PEND, DROP, BUSY}),
        32'd0);
    SCEN = 5'b00010;
    repeat (2) tick();
    SCEN = '0;
    RESET = 1'b0;
    tick();
    chk("t5_ignored", 32'(PEND), 32'd0);
    cmd_if.CMD_READY = 1'b1;
    pulse(5'b10000, '0);
    tick();
    chk("t5_idx", 32'(cmd_if.CMD_IDX), 32'd4);
    wait_idle("t5_wait", 1, 40);
    check_log("t5", 1, 4, 0, 0, 0);

    // New event on the very edge its slot is granted: re-pend, no drop.
    SCEN = 5'b00010;
    tick();
    tick();
    SCEN = '0;
    chk("t6_drop", 32'(DROP), 32'd0);
    chk("t6_pend", 32'(PEND), 32'b00010);
    chk("t6_idx", 32'(cmd_if.CMD_IDX), 32'd1);
    wait_idle("t6_wait", 2, 40);
    check_log("t6", 2, 1, 1, 0, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
